// File: rtl/conv_pass_scheduler_if.sv
// Bundle between conv_pass_scheduler and its neighbours: the command decoder
// (start/config), convolution_layer (control strobes, conv_done) and the
// activation BRAM (read strobe/address).
// Optional macro CONV_SCHED_TIMEOUT_EN adds the sticky timeout flag.
interface conv_pass_scheduler_if #(
    parameter int AddrBits    = 28,
    parameter int ChannelBits = 10,
    parameter int MatrixBits  = 14
);
    logic                   start;
    logic [ChannelBits-1:0] channel_count;
    logic [MatrixBits-1:0]  matrix_size;
    logic [AddrBits-1:0]    base_addr;
    logic                   conv_done;

    logic                   act_rd_en;
    logic [AddrBits-1:0]    act_addr;
    logic                   layer_en;
    logic                   layer_rst;
    logic                   accumulate;
    logic                   save;
    logic [ChannelBits-1:0] channel;
    logic                   busy;
    logic                   done;
`ifdef CONV_SCHED_TIMEOUT_EN
    logic                   timeout;
`endif

    // Scheduler side
    modport master (
`ifdef CONV_SCHED_TIMEOUT_EN
        output timeout,
`endif
        input  start, channel_count, matrix_size, base_addr, conv_done,
        output act_rd_en, act_addr, layer_en, layer_rst, accumulate, save,
        output channel, busy, done
    );

    // Environment side (decoder, layer, memory, bench)
    modport slave (
`ifdef CONV_SCHED_TIMEOUT_EN
        input  timeout,
`endif
        output start, channel_count, matrix_size, base_addr, conv_done,
        input  act_rd_en, act_addr, layer_en, layer_rst, accumulate, save,
        input  channel, busy, done
    );
endinterface

// File: rtl/conv_pass_scheduler.sv
// conv_pass_scheduler: runs convolution_layer once per input channel.
// Per channel: one layer_rst pulse, matrix_size^2 consecutive activation
// reads, then wait for conv_done. Channel 0 overwrites, later channels
// accumulate, only the last channel saves. Addresses run contiguously across
// channels. All outputs are registered.
// Optional macro CONV_SCHED_TIMEOUT_EN: 16-bit DRAIN watchdog with sticky
// timeout flag on the interface.
module conv_pass_scheduler #(
    parameter int AddrBits    = 28,
    parameter int ChannelBits = 10,
    parameter int MatrixBits  = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    conv_pass_scheduler_if.master bus
);
    localparam int PixBits = 2 * MatrixBits;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FINISH} state_t;

    state_t                 state_reg;
    logic [ChannelBits-1:0] count_reg;
    logic [ChannelBits-1:0] ch_reg;
    logic [PixBits-1:0]     size_sq_reg;
    logic [PixBits-1:0]     pix_reg;
    logic [AddrBits-1:0]    addr_reg;
    logic                   rd_en_reg;
    logic                   layer_en_reg;
    logic                   layer_rst_reg;
    logic                   acc_reg;
    logic                   save_reg;
    logic                   busy_reg;
    logic                   done_reg;
`ifdef CONV_SCHED_TIMEOUT_EN
    logic [15:0]            wd_reg;
    logic                   timeout_reg;
`endif

    // Channel sequencer: state, counters and every registered output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            ch_reg        <= '0;
            size_sq_reg   <= '0;
            pix_reg       <= '0;
            addr_reg      <= '0;
            rd_en_reg     <= 1'b0;
            layer_en_reg  <= 1'b0;
            layer_rst_reg <= 1'b0;
            acc_reg       <= 1'b0;
            save_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CONV_SCHED_TIMEOUT_EN
            wd_reg        <= '0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        count_reg   <= bus.channel_count;
                        size_sq_reg <= {{MatrixBits{1'b0}}, bus.matrix_size}
                                     * {{MatrixBits{1'b0}}, bus.matrix_size};
                        ch_reg      <= '0;
                        pix_reg     <= '0;
                        busy_reg    <= 1'b1;
`ifdef CONV_SCHED_TIMEOUT_EN
                        timeout_reg <= 1'b0;
`endif
                        // A matrix smaller than the 3x3 kernel yields no output
                        if (bus.channel_count == '0 || bus.matrix_size < MatrixBits'(3)) begin
                            state_reg <= FINISH;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg     <= CLEAR;
                            addr_reg      <= bus.base_addr;
                            layer_rst_reg <= 1'b1;
                            acc_reg       <= 1'b0;
                            save_reg      <= (bus.channel_count == ChannelBits'(1));
                        end
                    end
                end
                CLEAR: begin
                    layer_rst_reg <= 1'b0;
                    layer_en_reg  <= 1'b0;
                    rd_en_reg     <= 1'b1;
                    pix_reg       <= '0;
                    state_reg     <= STREAM;
                end
                STREAM: begin
                    // Address keeps counting past the last pixel so the next
                    // channel starts right behind this one
                    addr_reg     <= addr_reg + AddrBits'(1);
                    layer_en_reg <= 1'b1;
                    if (pix_reg == size_sq_reg - PixBits'(1)) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= DRAIN;
`ifdef CONV_SCHED_TIMEOUT_EN
                        wd_reg    <= '0;
`endif
                    end else begin
                        pix_reg <= pix_reg + PixBits'(1);
                    end
                end
                DRAIN: begin
                    if (bus.conv_done) begin
                        layer_en_reg <= 1'b0;
                        if (ch_reg == count_reg - ChannelBits'(1)) begin
                            state_reg <= FINISH;
                            done_reg  <= 1'b1;
                        end else begin
                            ch_reg        <= ch_reg + ChannelBits'(1);
                            layer_rst_reg <= 1'b1;
                            acc_reg       <= 1'b1;
                            save_reg      <= (ch_reg + ChannelBits'(1) == count_reg - ChannelBits'(1));
                            state_reg     <= CLEAR;
                        end
`ifdef CONV_SCHED_TIMEOUT_EN
                    end else if (wd_reg == 16'hFFFE) begin
                        // 65535th DRAIN cycle without conv_done: give up
                        timeout_reg  <= 1'b1;
                        done_reg     <= 1'b1;
                        layer_en_reg <= 1'b0;
                        state_reg    <= FINISH;
                    end else begin
                        wd_reg <= wd_reg + 16'd1;
`endif
                    end
                end
                FINISH: begin
                    done_reg     <= 1'b0;
                    busy_reg     <= 1'b0;
                    layer_en_reg <= 1'b0;
                    acc_reg      <= 1'b0;
                    save_reg     <= 1'b0;
                    ch_reg       <= '0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.act_rd_en  = rd_en_reg;
    assign bus.act_addr   = addr_reg;
    assign bus.layer_en   = layer_en_reg;
    assign bus.layer_rst  = layer_rst_reg;
    assign bus.accumulate = acc_reg;
    assign bus.save       = save_reg;
    assign bus.channel    = ch_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
`ifdef CONV_SCHED_TIMEOUT_EN
    assign bus.timeout    = timeout_reg;
`endif
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Directed bench for conv_pass_scheduler (default build).
module tb_conv_pass_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_pass_scheduler_if #(.AddrBits(28), .ChannelBits(10), .MatrixBits(14)) bus ();

    conv_pass_scheduler #(.AddrBits(28), .ChannelBits(10), .MatrixBits(14)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Observations gathered by run_job
    logic [27:0] rd_q[$];
    int  rst_n, busy_cyc, done_cyc, cd_cyc, done_cnt, lag_bad, contig_bad;
    bit  acc_h[0:7];
    bit  save_h[0:7];
    logic [9:0] chan_h[0:7];
    bit  post_done, post_busy, finished;

    // Start a job, play the layer (conv_done 3 cycles after the last read) and
    // record what the scheduler did, one negedge sample per cycle.
    task automatic run_job(input logic [9:0] cnt, input logic [13:0] sz, input logic [27:0] base,
                           input int inj_start, input bit hold_cd, input int rst_at, input int budget);
        int  gap;
        bit  prev_rd;
        rd_q.delete();
        rst_n = 0; busy_cyc = 0; done_cyc = -1; cd_cyc = -1; done_cnt = 0;
        lag_bad = 0; contig_bad = 0; finished = 0; post_done = 1; post_busy = 1;
        @(negedge clk);
        bus.start = 1'b1; bus.channel_count = cnt; bus.matrix_size = sz; bus.base_addr = base;
        @(negedge clk);
        // Scramble config to show the latched copies are used
        bus.start = 1'b0; bus.channel_count = 10'($urandom); bus.matrix_size = 14'($urandom);
        bus.base_addr = 28'($urandom);
        gap = -1; prev_rd = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (bus.busy) busy_cyc++;
            if (bus.act_rd_en) begin
                if (rd_q.size() > 0 && bus.act_addr !== 28'(rd_q[$] + 28'd1)) contig_bad++;
                rd_q.push_back(bus.act_addr);
            end
            if (prev_rd && !bus.layer_en) lag_bad++;
            if (bus.act_rd_en && !prev_rd && bus.layer_en) lag_bad++;
            if (bus.layer_rst && rst_n < 8) begin
                acc_h[rst_n] = bus.accumulate; save_h[rst_n] = bus.save; chan_h[rst_n] = bus.channel;
                rst_n++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (bus.layer_en) lag_bad++;
            end
            bus.conv_done = 1'b0;
            bus.start = 1'b0;
            if (rst_at >= 0 && bus.act_rd_en && rd_q.size() == rst_at) begin
                rst = 1'b1;
                return;
            end
            if (bus.done) begin
                finished = 1;
                break;
            end
            if (inj_start >= 0 && bus.act_rd_en && rd_q.size() == inj_start) bus.start = 1'b1;
            if (hold_cd && bus.act_rd_en) bus.conv_done = 1'b1;
            if (prev_rd && !bus.act_rd_en) gap = 3;
            if (gap > 0) begin
                gap--;
                if (gap == 0) begin
                    bus.conv_done = 1'b1;
                    cd_cyc = cyc;
                end
            end
            prev_rd = bus.act_rd_en;
            @(negedge clk);
        end
        if (finished) begin
            @(negedge clk);
            post_done = bus.done;
            post_busy = bus.busy;
        end else begin
            errors++; checks++;
            $display("FAIL job_timeout: done_o not seen within %0d cycles, required 1 pulse", budget);
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.channel_count = 0; bus.matrix_size = 0; bus.base_addr = 0; bus.conv_done = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.act_rd_en, bus.layer_en, bus.layer_rst, bus.accumulate, bus.save} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000000",
                {bus.busy, bus.done, bus.act_rd_en, bus.layer_en, bus.layer_rst, bus.accumulate, bus.save});
        end
        checks++;
        if (bus.act_addr !== 28'h0 || bus.channel !== 10'h0) begin
            errors++;
            $display("FAIL reset_addr_ch: got addr=%0h ch=%0d required 0/0", bus.act_addr, bus.channel);
        end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_single();
        run_job(10'd1, 14'd5, 28'h100, -1, 1'b0, -1, 400);
        checks++;
        if (rd_q.size() != 25) begin errors++; $display("FAIL single_reads: got %0d required 25", rd_q.size()); end
        checks++;
        if (rd_q.size() == 0 || rd_q[0] !== 28'h100 || rd_q[$] !== 28'h118 || contig_bad != 0) begin
            errors++;
            $display("FAIL single_addr: first=%0h last=%0h gaps=%0d required 100/118/0",
                rd_q.size() ? rd_q[0] : 28'h0, rd_q.size() ? rd_q[$] : 28'h0, contig_bad);
        end
        checks++;
        if (rst_n != 1 || acc_h[0] !== 1'b0 || save_h[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_flags: rst_pulses=%0d acc=%b save=%b required 1/0/1", rst_n, acc_h[0], save_h[0]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != cd_cyc + 1) begin
            errors++;
            $display("FAIL single_done: pulses=%0d at=%0d required 1 at %0d", done_cnt, done_cyc, cd_cyc + 1);
        end
        checks++;
        if (lag_bad != 0 || post_done !== 1'b0 || post_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_layer_en: lag_errors=%0d done_after=%b busy_after=%b required 0/0/0",
                lag_bad, post_done, post_busy);
        end
        $display("single: reads=%0d done_at=%0d", rd_q.size(), done_cyc);
    endtask

    task automatic test_multi();
        run_job(10'd3, 14'd4, 28'h0, -1, 1'b0, -1, 600);
        checks++;
        if (rd_q.size() != 48 || rd_q[0] !== 28'h0 || rd_q[$] !== 28'd47 || contig_bad != 0) begin
            errors++;
            $display("FAIL multi_reads: got %0d reads gaps=%0d required 48 contiguous 0..47", rd_q.size(), contig_bad);
        end
        checks++;
        if (rst_n != 3 || {acc_h[2], acc_h[1], acc_h[0]} !== 3'b110) begin
            errors++;
            $display("FAIL multi_accumulate: pulses=%0d acc=%b%b%b required 3 and 110",
                rst_n, acc_h[2], acc_h[1], acc_h[0]);
        end
        checks++;
        if ({save_h[2], save_h[1], save_h[0]} !== 3'b100) begin
            errors++;
            $display("FAIL multi_save: got %b%b%b required 100", save_h[2], save_h[1], save_h[0]);
        end
        checks++;
        if (chan_h[0] !== 10'd0 || chan_h[1] !== 10'd1 || chan_h[2] !== 10'd2) begin
            errors++;
            $display("FAIL multi_channel: got %0d,%0d,%0d required 0,1,2", chan_h[0], chan_h[1], chan_h[2]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != cd_cyc + 1 || lag_bad != 0) begin
            errors++;
            $display("FAIL multi_done: pulses=%0d at=%0d lag_errors=%0d required 1 at %0d, 0",
                done_cnt, done_cyc, lag_bad, cd_cyc + 1);
        end
        $display("multi: reads=%0d rst_pulses=%0d done_at=%0d", rd_q.size(), rst_n, done_cyc);
    endtask

    task automatic test_degenerate();
        logic [9:0]  cnts[2];
        logic [13:0] sizes[2];
        cnts = '{10'd0, 10'd3};
        sizes = '{14'd6, 14'd2};
        for (int k = 0; k < 2; k++) begin
            run_job(cnts[k], sizes[k], 28'h80, -1, 1'b0, -1, 20);
            checks++;
            if (rd_q.size() != 0 || rst_n != 0) begin
                errors++;
                $display("FAIL degen%0d_reads: got %0d reads %0d rst pulses required 0/0", k, rd_q.size(), rst_n);
            end
            checks++;
            if (done_cyc != 1 || busy_cyc != 1 || post_done !== 1'b0 || post_busy !== 1'b0) begin
                errors++;
                $display("FAIL degen%0d_timing: done_at=%0d busy_cycles=%0d after=%b%b required 1/1/00",
                    k, done_cyc, busy_cyc, post_done, post_busy);
            end
            $display("degenerate count=%0d size=%0d: done_at=%0d", cnts[k], sizes[k], done_cyc);
        end
    endtask

    task automatic test_ignore_inputs();
        run_job(10'd2, 14'd3, 28'h300, 4, 1'b1, -1, 300);
        checks++;
        if (rd_q.size() != 18 || rd_q[0] !== 28'h300 || contig_bad != 0) begin
            errors++;
            $display("FAIL ignore_reads: got %0d reads gaps=%0d required 18 contiguous from 300", rd_q.size(), contig_bad);
        end
        checks++;
        if (rst_n != 2 || done_cnt != 1 || done_cyc != cd_cyc + 1) begin
            errors++;
            $display("FAIL ignore_done: rst_pulses=%0d done_pulses=%0d at=%0d required 2/1 at %0d",
                rst_n, done_cnt, done_cyc, cd_cyc + 1);
        end
        $display("ignore start/conv_done: reads=%0d done_at=%0d", rd_q.size(), done_cyc);
    endtask

    task automatic test_reset_mid();
        int stray;
        run_job(10'd2, 14'd4, 28'h200, -1, 1'b0, 26, 300);
        @(negedge clk);
        rst = 1'b0;
        bus.conv_done = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.act_rd_en, bus.layer_en, bus.layer_rst, bus.accumulate, bus.save} !== 7'b0
            || bus.act_addr !== 28'h0 || bus.channel !== 10'h0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b addr=%0h ch=%0d required all 0",
                {bus.busy, bus.done, bus.act_rd_en, bus.layer_en, bus.layer_rst, bus.accumulate, bus.save},
                bus.act_addr, bus.channel);
        end
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.act_rd_en) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles required 0", stray); end
        run_job(10'd1, 14'd3, 28'h40, -1, 1'b0, -1, 200);
        checks++;
        if (rd_q.size() != 9 || rd_q[0] !== 28'h40 || contig_bad != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL midreset_rerun: reads=%0d done=%0d required 9 from 40, 1 done", rd_q.size(), done_cnt);
        end
        $display("mid-run reset then rerun: reads=%0d", rd_q.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_degenerate();
        test_ignore_inputs();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
